// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, address
// field positions and access-error reasons.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Byte address = {word index, byte offset}; words are 32 bits wide.
    localparam int WORD_LSB   = 2;
    localparam int BYTE_OFF_W = 2;
    localparam int STRB_W     = 4;
    localparam int CNT_W      = 4;

    typedef logic [1:0] err_reason_t;

    localparam err_reason_t ERR_NONE     = 2'd0;
    localparam err_reason_t ERR_MISALIGN = 2'd1;
    localparam err_reason_t ERR_RANGE    = 2'd2;

    // Misalignment takes priority so a bad offset is never reported as range.
    function automatic err_reason_t classify_access(input logic misaligned,
                                                    input logic out_of_range);
        err_reason_t reason;
        reason = ERR_NONE;
        if (misaligned) begin
            reason = ERR_MISALIGN;
        end else if (out_of_range) begin
            reason = ERR_RANGE;
        end
        return reason;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with synchronous byte-masked write and a registered
// read port; contents are deliberately not cleared by reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register only moves on a committed load, so it holds through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with valid/ready request/response channels and a
// fixed wait-state latency. Optional byte strobes: DATA_MEM_BYTE_STROBE_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef DATA_MEM_BYTE_STROBE_EN
    input  logic [STRB_W-1:0] req_wstrb,
`endif
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W     = $clog2(DEPTH);
    localparam int WIDX_W    = ADDR_W - WORD_LSB;
    localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(LATENCY - 1);

    dmem_state_e       state, next_state;
    logic [CNT_W-1:0]  cnt, next_cnt;

    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [STRB_W-1:0] lat_wstrb;
    logic              resp_err_q;
    logic              rdata_en;

    logic              cur_write;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [STRB_W-1:0] cur_wstrb;
    logic [STRB_W-1:0] in_wstrb;
    err_reason_t       cur_reason;
    logic              accept;
    logic              commit;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] arr_rdata;

`ifdef DATA_MEM_BYTE_STROBE_EN
    assign in_wstrb = req_wstrb;
`else
    assign in_wstrb = '1;
`endif

    assign req_ready  = (state == IDLE) && rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_err_q;
    assign resp_rdata = rdata_en ? arr_rdata : '0;

    // With LATENCY==1 the commit happens on the accepting edge itself, so the
    // live request is used in IDLE and the latched copy everywhere else.
    always_comb begin
        cur_write = lat_write;
        cur_addr  = lat_addr;
        cur_wdata = lat_wdata;
        cur_wstrb = lat_wstrb;
        if (state == IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_wstrb = in_wstrb;
        end
        cur_reason = classify_access(cur_addr[BYTE_OFF_W-1:0] != '0,
                                     cur_addr[ADDR_W-1:WORD_LSB] >= DEPTH_LIM);
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                next_cnt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    assign commit = (next_state == RESP) && (state != RESP);
    assign mem_we = commit && cur_write  && (cur_reason == ERR_NONE);
    assign mem_re = commit && !cur_write && (cur_reason == ERR_NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wstrb  <= '0;
            resp_err_q <= 1'b0;
            rdata_en   <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= in_wstrb;
            end
            if (commit) begin
                resp_err_q <= (cur_reason != ERR_NONE);
                rdata_en   <= mem_re;
            end else if ((state == RESP) && resp_ready) begin
                resp_err_q <= 1'b0;
                rdata_en   <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (cur_addr[WORD_LSB +: IDX_W]),
        .wdata (cur_wdata),
        .wstrb (cur_wstrb),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: requests push expected responses
// from a word-array model; a monitor checks every presented response.
module tb_data_mem_responder;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int LAT    = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
`ifdef DATA_MEM_BYTE_STROBE_EN
    logic [3:0]        req_wstrb = 4'hF;
`endif
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic        hold_off = 1'b0;
    logic        prev_open = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef DATA_MEM_BYTE_STROBE_EN
        .req_wstrb  (req_wstrb),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: condition not met (cycle %0d)", name, cyc);
    endtask

    // Reference: a word is in range and aligned, or the access is an error.
    function automatic void model_access(input logic wr, input logic [31:0] addr,
                                         input logic [31:0] wd, input logic [3:0] strb,
                                         output logic [31:0] rd, output logic err);
        int unsigned word;
        word = addr / 4;
        err  = ((addr % 4) != 0) || (word >= DEPTH);
        rd   = 32'h0;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model[word][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                rd = model[word];
            end
        end
    endfunction

    // Requester-side ready: random, or held low to create backpressure.
    always @(posedge clk) begin
        #1;
        resp_ready = hold_off ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency on the first valid cycle, content on every valid cycle.
    always @(negedge clk) begin
        if (!rst) begin
            prev_open <= 1'b0;
        end else if (resp_valid) begin
            if (sb.size() == 0) begin
                flag_fail("unexpected_resp");
            end else begin
                if (!prev_open) begin
                    check_output("latency", 32'(cyc - sb[0].acc_cyc), 32'(LAT - 1));
                end
                check_output("rdata", resp_rdata, sb[0].rdata);
                check_output("err", {31'h0, resp_err}, {31'h0, sb[0].err});
                check_output("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
                if (resp_ready) void'(sb.pop_front());
            end
            prev_open <= !resp_ready;
        end else begin
            prev_open <= 1'b0;
        end
    end

    task automatic apply_stimulus(input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [3:0] strb_in);
        logic [31:0] rd;
        logic        err;
        logic [3:0]  strb;
        exp_t        e;
        int          t;
`ifdef DATA_MEM_BYTE_STROBE_EN
        strb = strb_in;
`else
        strb = 4'hF;
        if (strb_in == 4'h0) strb = 4'hF;
`endif
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
`ifdef DATA_MEM_BYTE_STROBE_EN
        req_wstrb = strb;
`endif
        t = 0;
        while (!req_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) begin
            flag_fail("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        model_access(wr, addr, wd, strb, rd, err);
        e.rdata   = rd;
        e.err     = err;
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) flag_fail("drain_timeout");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        logic [31:0] a;
        $display("[TB] start");

        // Reset held with a pending request: nothing accepted, nothing returned.
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("rst_req_ready", {31'h0, req_ready}, 32'h0);
            check_output("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_output("idle_req_ready", {31'h0, req_ready}, 32'h1);
        check_output("idle_resp_rdata", resp_rdata, 32'h0);

        // Give every word a known value before any load.
        for (int w = 0; w < DEPTH; w++) apply_stimulus(1'b1, 32'(w * 4), $urandom, 4'hF);

        apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'hF);
        apply_stimulus(1'b0, 32'h13, 32'h0, 4'hF);
        apply_stimulus(1'b1, 32'h400, 32'hCAFEF00D, 4'hF);
        apply_stimulus(1'b0, 32'h0, 32'h0, 4'hF);
        apply_stimulus(1'b0, 32'h3FC, 32'h0, 4'hF);
        apply_stimulus(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF);

`ifdef DATA_MEM_BYTE_STROBE_EN
        apply_stimulus(1'b1, 32'h8, 32'hAABBCCDD, 4'hF);
        apply_stimulus(1'b1, 32'h8, 32'h11223344, 4'b0101);
        apply_stimulus(1'b0, 32'h8, 32'h0, 4'hF);
        apply_stimulus(1'b1, 32'h8, 32'h55667788, 4'b0000);
        apply_stimulus(1'b0, 32'h8, 32'h0, 4'hF);
`endif
        wait_drain();

        // Backpressure: response must hold while a second request is refused.
        hold_off = 1'b1;
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'hF);
        t = 0;
        while (!resp_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!resp_valid) flag_fail("bp_resp_timeout");
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h20;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_output("bp_req_ready", {31'h0, req_ready}, 32'h0);
            check_output("bp_resp_valid", {31'h0, resp_valid}, 32'h1);
        end
        req_valid = 1'b0;
        hold_off  = 1'b0;
        wait_drain();

        // Abort: reset while the store waits, so the word keeps its old value.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_output("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_output("abort_no_resp", {31'h0, resp_valid}, 32'h0);
        end
        apply_stimulus(1'b0, 32'h20, 32'h0, 4'hF);

        // Random traffic across aligned, misaligned and out-of-range addresses.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0: a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                1: a = 32'((DEPTH + $urandom_range(0, 1000)) * 4);
                default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            apply_stimulus($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)));
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
